// File: rtl/clk_div_cfg_ctrl_if.sv
// Requester-side bundle for clk_div_cfg_ctrl: two independent ratio-change requesters,
// each with a valid/ready request channel and done/err completion pulses.
interface clk_div_cfg_ctrl_if #(
   parameter int RATIO_W = 4
);
   logic               i_req0_valid;
   logic [RATIO_W-1:0] i_req0_ratio;
   logic               o_req0_ready;
   logic               o_req0_done;
   logic               o_req0_err;

   logic               i_req1_valid;
   logic [RATIO_W-1:0] i_req1_ratio;
   logic               o_req1_ready;
   logic               o_req1_done;
   logic               o_req1_err;

   modport master (
      output i_req0_valid, i_req0_ratio, i_req1_valid, i_req1_ratio,
      input  o_req0_ready, o_req0_done, o_req0_err,
      input  o_req1_ready, o_req1_done, o_req1_err
   );

   modport slave (
      input  i_req0_valid, i_req0_ratio, i_req1_valid, i_req1_ratio,
      output o_req0_ready, o_req0_done, o_req0_err,
      output o_req1_ready, o_req1_done, o_req1_err
   );
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Run-time reconfiguration controller for the integer clock divider: arbitrates two
// requesters round-robin and applies a new ratio through a gate -> load -> settle sequence.
module clk_div_cfg_ctrl #(
   parameter int RATIO_W     = 4,
   parameter int RESET_RATIO = 8,
   parameter int MIN_RATIO   = 2,
   parameter int GATE_CYC    = 16,
   parameter int SETTLE_CYC  = 32
) (
   input  logic               i_ref_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   clk_div_cfg_ctrl_if.slave  req,
   output logic [RATIO_W-1:0] o_div_ratio,
   output logic               o_clk_en,
   output logic               o_busy
);
   localparam int CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]   GATE_LAST   = CNT_W'(GATE_CYC - 1);
   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [RATIO_W-1:0] MIN_R       = RATIO_W'(MIN_RATIO);
   localparam logic [RATIO_W-1:0] RESET_R     = RATIO_W'(RESET_RATIO);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_GATE   = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t               state_r, state_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [RATIO_W-1:0]   ratio_r, ratio_s;
   logic [RATIO_W-1:0]   lat_ratio_r;
   logic                 served_r;
   logic                 last_r;
   logic                 run_r;
   logic                 clk_en_r, clk_en_s;
   logic                 busy_r, busy_s;
   logic [1:0]           done_r, done_s;
   logic [1:0]           err_r, err_s;
   logic                 grant_vld_s;
   logic                 grant_idx_s;
   logic [RATIO_W-1:0]   grant_ratio_s;

   // Round-robin grant; ready stays combinational so a lone valid is granted in its own cycle.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = 1'b0;
      if (run_r && (state_r == ST_IDLE)) begin
         if (req.i_req0_valid && req.i_req1_valid) begin
            grant_vld_s = 1'b1;
            grant_idx_s = ~last_r;
         end else if (req.i_req0_valid) begin
            grant_vld_s = 1'b1;
            grant_idx_s = 1'b0;
         end else if (req.i_req1_valid) begin
            grant_vld_s = 1'b1;
            grant_idx_s = 1'b1;
         end else begin
            grant_vld_s = 1'b0;
         end
      end else begin
         grant_vld_s = 1'b0;
      end
   end

   assign grant_ratio_s    = grant_idx_s ? req.i_req1_ratio : req.i_req0_ratio;
   assign req.o_req0_ready = grant_vld_s & ~grant_idx_s;
   assign req.o_req1_ready = grant_vld_s &  grant_idx_s;

   // Next-state, counter and next values of every registered output.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      ratio_s = ratio_r;
      done_s  = 2'b00;
      err_s   = 2'b00;
      case (state_r)
         ST_IDLE: begin
            if (grant_vld_s) begin
               if (grant_ratio_s < MIN_R) begin
                  err_s = grant_idx_s ? 2'b10 : 2'b01;
               end else if (grant_ratio_s == ratio_r) begin
                  done_s = grant_idx_s ? 2'b10 : 2'b01;
               end else begin
                  state_s = ST_GATE;
                  cnt_s   = '0;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GATE: begin
            if (cnt_r == GATE_LAST) begin
               state_s = ST_LOAD;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_LOAD: begin
            state_s = ST_SETTLE;
            cnt_s   = '0;
            ratio_s = lat_ratio_r;
         end
         ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
               state_s = ST_DONE;
               cnt_s   = '0;
               done_s  = served_r ? 2'b10 : 2'b01;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase

      // The divider is only enabled in states where its ratio is stable.
      case (state_s)
         ST_IDLE, ST_SETTLE, ST_DONE: clk_en_s = i_en;
         default:                     clk_en_s = 1'b0;
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State register, latched request and registered outputs.
   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         ratio_r     <= RESET_R;
         lat_ratio_r <= RESET_R;
         served_r    <= 1'b0;
         last_r      <= 1'b1;
         run_r       <= 1'b0;
         clk_en_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 2'b00;
         err_r       <= 2'b00;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         ratio_r  <= ratio_s;
         run_r    <= 1'b1;
         clk_en_r <= clk_en_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         err_r    <= err_s;
         if (grant_vld_s) begin
            lat_ratio_r <= grant_ratio_s;
            served_r    <= grant_idx_s;
            last_r      <= grant_idx_s;
         end
      end
   end

   assign o_div_ratio     = ratio_r;
   assign o_clk_en        = clk_en_r;
   assign o_busy          = busy_r;
   assign req.o_req0_done = done_r[0];
   assign req.o_req1_done = done_r[1];
   assign req.o_req0_err  = err_r[0];
   assign req.o_req1_err  = err_r[1];
endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Self-checking bench for clk_div_cfg_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a cycle-timeline reference model.
module tb_clk_div_cfg_ctrl;
   localparam int NCYC = 2000;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] div_ratio;
   logic       clk_en;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   clk_div_cfg_ctrl_if #(.RATIO_W(4)) rif ();

   clk_div_cfg_ctrl dut (
      .i_ref_clk   (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .req         (rif),
      .o_div_ratio (div_ratio),
      .o_clk_en    (clk_en),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int         idx;
      logic [3:0] ratio;
      logic       en_v;
      int         exp_lat;
      logic [3:0] exp_pulse;   // {err1, err0, done1, done0}
      int         exp_low;
      int         exp_busy;
      logic [3:0] exp_ratio;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] pulses_now();
      return {rif.o_req1_err, rif.o_req0_err, rif.o_req1_done, rif.o_req0_done};
   endfunction

   function automatic logic [3:0] pick(input logic [3:0] cur);
      int sel;
      sel = $urandom_range(0, 7);
      if (sel < 2) return cur;
      else if (sel == 2) return 4'($urandom_range(0, 1));
      else return 4'($urandom_range(0, 15));
   endfunction

   // Issue one request and measure accept-to-pulse latency, gated and busy cycles.
   task automatic run_req(input int idx, input logic [3:0] ratio, input logic en_v,
                          output int lat, output logic [3:0] pulses,
                          output int low_cnt, output int busy_cnt);
      bit got;
      got = 1'b0;
      lat = -1; pulses = 4'd0; low_cnt = 0; busy_cnt = 0;
      @(posedge clk); #1; en = en_v;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (idx == 0) begin rif.i_req0_valid = 1'b1; rif.i_req0_ratio = ratio; end
      else begin rif.i_req1_valid = 1'b1; rif.i_req1_ratio = ratio; end
      for (int w = 0; w < 100 && !got; w++) begin
         @(negedge clk);
         got = (idx == 0) ? rif.o_req0_ready : rif.o_req1_ready;
         @(posedge clk); #1;
      end
      rif.i_req0_valid = 1'b0;
      rif.i_req1_valid = 1'b0;
      if (!got) begin
         n_checks++; n_errors++;
         $display("FAIL accept_timeout: req%0d never saw ready", idx);
      end else begin
         for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(negedge clk);
            if (!clk_en) low_cnt++;
            if (busy) busy_cnt++;
            if (pulses_now() != 4'd0) begin lat = n; pulses = pulses_now(); end
         end
      end
   endtask

   // Reference model state for the randomized phase.
   logic [3:0] exp_p [0:NCYC+63];
   bit         en_hist [0:NCYC];

   initial begin
      int lat, low_cnt, busy_cnt, npulse, nbusy, code;
      logic [3:0] pulses;
      int acc_q[$];
      int done_q[$];
      bit a0, a1;
      logic [3:0] mr, pend_r, rt;
      bit last, pend, idle, er0, er1, exp_en;
      int free_at, gate_lo, gate_hi, apply_at, idx;
      logic [1:0] acc;
      logic [11:0] act, exp;

      vecs[0] = '{0, 4'd8,  1'b1, 1,  4'b0001, 0,  0,  4'd8};
      vecs[1] = '{0, 4'd4,  1'b1, 50, 4'b0001, 17, 50, 4'd4};
      vecs[2] = '{1, 4'd1,  1'b1, 1,  4'b1000, 0,  0,  4'd4};
      vecs[3] = '{1, 4'd0,  1'b1, 1,  4'b1000, 0,  0,  4'd4};
      vecs[4] = '{1, 4'd15, 1'b1, 50, 4'b0010, 17, 50, 4'd15};
      vecs[5] = '{0, 4'd2,  1'b1, 50, 4'b0001, 17, 50, 4'd2};
      vecs[6] = '{0, 4'd2,  1'b1, 1,  4'b0001, 0,  0,  4'd2};
      vecs[7] = '{1, 4'd3,  1'b0, 50, 4'b0010, 50, 50, 4'd3};

      rst_n = 1'b0; en = 1'b0;
      rif.i_req0_valid = 1'b0; rif.i_req0_ratio = 4'd0;
      rif.i_req1_valid = 1'b0; rif.i_req1_ratio = 4'd0;
      #32;
      check("reset_state", {24'd0, rif.o_req1_ready, rif.o_req0_ready, pulses_now(), clk_en, busy},
            32'd0);
      check("reset_ratio", 32'(div_ratio), 32'd8);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_req(vecs[i].idx, vecs[i].ratio, vecs[i].en_v, lat, pulses, low_cnt, busy_cnt);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_pulse", i), 32'(pulses), 32'(vecs[i].exp_pulse));
         check($sformatf("vec%0d_clk_en_low", i), low_cnt, vecs[i].exp_low);
         check($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
         check($sformatf("vec%0d_ratio", i), 32'(div_ratio), 32'(vecs[i].exp_ratio));
      end

      // Both requesters together: req0 (not served last) first, then req1.
      @(posedge clk); #1;
      en = 1'b1;
      rif.i_req0_valid = 1'b1; rif.i_req0_ratio = 4'd6;
      rif.i_req1_valid = 1'b1; rif.i_req1_ratio = 4'd10;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (rif.o_req0_done) done_q.push_back(0);
         if (rif.o_req1_done) done_q.push_back(1);
         a0 = rif.i_req0_valid && rif.o_req0_ready;
         a1 = rif.i_req1_valid && rif.o_req1_ready;
         if (a0) acc_q.push_back(0);
         if (a1) acc_q.push_back(1);
         @(posedge clk); #1;
         if (a0) rif.i_req0_valid = 1'b0;
         if (a1) rif.i_req1_valid = 1'b0;
      end
      code = (acc_q.size() == 2) ? acc_q[0] * 2 + acc_q[1] : 99;
      check("rr_accept_order", code, 1);
      code = (done_q.size() == 2) ? done_q[0] * 2 + done_q[1] : 99;
      check("rr_done_order", code, 1);
      check("rr_final_ratio", 32'(div_ratio), 32'd10);

      // Reset asserted in the middle of SETTLE drops the request silently.
      rif.i_req0_valid = 1'b1; rif.i_req0_ratio = 4'd5;
      a0 = 1'b0;
      for (int w = 0; w < 20 && !a0; w++) begin
         @(negedge clk);
         a0 = rif.o_req0_ready;
         @(posedge clk); #1;
      end
      rif.i_req0_valid = 1'b0;
      check("mid_accept", 32'(a0), 32'd1);
      repeat (30) @(posedge clk);
      #2;
      check("pre_reset_state", {27'd0, busy, div_ratio}, {27'd0, 1'b1, 4'd5});
      rst_n = 1'b0;
      #1;
      check("async_reset", {27'd0, clk_en, busy, div_ratio}, {27'd0, 1'b0, 1'b0, 4'd8});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      npulse = 0; nbusy = 0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         if (pulses_now() != 4'd0) npulse++;
         if (busy) nbusy++;
      end
      check("post_reset_no_pulse", npulse, 0);
      check("post_reset_idle", {nbusy, 28'd0} | 32'(div_ratio), 32'd8);

      // Randomized phase: expected outputs come from a per-cycle event timeline.
      for (int i = 0; i < NCYC + 64; i++) exp_p[i] = 4'd0;
      en_hist[0] = en;
      mr = 4'd8; last = 1'b1; pend = 1'b0; pend_r = 4'd0;
      free_at = 0; gate_lo = 1; gate_hi = 0; apply_at = 0; acc = 2'b00;
      for (int c = 1; c <= NCYC; c++) begin
         @(posedge clk); #1;
         if (acc[0]) rif.i_req0_valid = 1'b0;
         if (acc[1]) rif.i_req1_valid = 1'b0;
         if (!rif.i_req0_valid && $urandom_range(0, 3) == 0) begin
            rif.i_req0_valid = 1'b1; rif.i_req0_ratio = pick(mr);
         end
         if (!rif.i_req1_valid && $urandom_range(0, 3) == 0) begin
            rif.i_req1_valid = 1'b1; rif.i_req1_ratio = pick(mr);
         end
         if ($urandom_range(0, 19) == 0) en = ~en;
         en_hist[c] = en;
         if (pend && c >= apply_at) begin mr = pend_r; pend = 1'b0; end
         @(negedge clk);
         idle = (c >= free_at);
         er0 = 1'b0; er1 = 1'b0;
         if (idle) begin
            if (rif.i_req0_valid && rif.i_req1_valid) begin
               if (last) er0 = 1'b1; else er1 = 1'b1;
            end else begin
               er0 = rif.i_req0_valid; er1 = rif.i_req1_valid;
            end
         end
         exp_en = (c >= gate_lo && c <= gate_hi) ? 1'b0 : en_hist[c-1];
         exp = {er1, er0, exp_p[c], exp_en, ~idle, mr};
         act = {rif.o_req1_ready, rif.o_req0_ready, pulses_now(), clk_en, busy, div_ratio};
         check($sformatf("rand_cyc%0d", c), 32'(act), 32'(exp));
         acc = {er1 & rif.i_req1_valid, er0 & rif.i_req0_valid};
         if (acc != 2'b00) begin
            idx = acc[1] ? 1 : 0;
            rt = acc[1] ? rif.i_req1_ratio : rif.i_req0_ratio;
            last = acc[1];
            if (rt < 4'd2) begin
               exp_p[c+1][2+idx] = 1'b1;
            end else if (rt == mr) begin
               exp_p[c+1][idx] = 1'b1;
            end else begin
               gate_lo = c + 1; gate_hi = c + 17; apply_at = c + 18;
               pend = 1'b1; pend_r = rt;
               exp_p[c+50][idx] = 1'b1;
               free_at = c + 51;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
